// File: rtl/loopback_mux_sipo.sv
// loopback_mux_sipo: registered multi-lane selector between line receive data and
// PISO loopback data feeding the SIPO. EWRAP is synchronized internally and every
// change of source is separated by GUARD idle bit-times.
// Optional build macro: LOOPBACK_MUX_SIPO_PRBS_EN adds prbs_sel and a PRBS7 source.
module loopback_mux_sipo #(
  parameter int   LANES       = 1,
  parameter int   SYNC_STAGES = 2,
  parameter int   GUARD       = 10,
  parameter logic IDLE_BIT    = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LANES-1:0] serial_sipo,
  input  logic [LANES-1:0] PMD_UNITDATA_indication,
  input  logic             EWRAP,
`ifdef LOOPBACK_MUX_SIPO_PRBS_EN
  input  logic             prbs_sel,
`endif
  output logic [LANES-1:0] mux_sipo_out,
  output logic             wrap_active,
  output logic             switching,
  output logic [7:0]       sel_change_cnt
);

  localparam int CW = $clog2(GUARD + 1);
  localparam logic [CW-1:0] GUARD_LOAD = CW'(GUARD - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {LINE, G2WRAP, WRAP, G2LINE} state_t;

  state_t                 state_reg, state_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic                   guard_done;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   ewrap_s;
  logic [LANES-1:0]       data_next;
  logic                   sel_line, sel_wrap;

  assign ewrap_s = sync_reg[SYNC_STAGES-1];

  // EWRAP synchronizer chain; the last stage is the only one the FSM looks at
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_reg <= '0;
    else        sync_reg <= {sync_reg[SYNC_STAGES-2:0], EWRAP};
  end

  // State and guard counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= LINE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic; a reversal mid-guard restarts a full guard toward the new side
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    guard_done = 1'b0;
    case (state_reg)
      LINE: begin
        if (ewrap_s) begin
          state_next = G2WRAP;
          cnt_next   = GUARD_LOAD;
        end
      end
      G2WRAP: begin
        if (!ewrap_s) begin
          state_next = G2LINE;
          cnt_next   = GUARD_LOAD;
        end else if (cnt_reg == '0) begin
          state_next = WRAP;
          guard_done = 1'b1;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      WRAP: begin
        if (!ewrap_s) begin
          state_next = G2LINE;
          cnt_next   = GUARD_LOAD;
        end
      end
      G2LINE: begin
        if (ewrap_s) begin
          state_next = G2WRAP;
          cnt_next   = GUARD_LOAD;
        end else if (cnt_reg == '0) begin
          state_next = LINE;
          guard_done = 1'b1;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      default: state_next = LINE;
    endcase
  end

  assign sel_line = (state_next == LINE);
  assign sel_wrap = (state_next == WRAP);

`ifdef LOOPBACK_MUX_SIPO_PRBS_EN
  logic [6:0] prbs_reg;
  logic       prbs_on;

  // Free-running PRBS7 (x^7+x^6+1), independent of the selection state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prbs_reg <= 7'h7F;
    else        prbs_reg <= {prbs_reg[5:0], prbs_reg[6] ^ prbs_reg[5]};
  end

  assign prbs_on = prbs_sel & (sel_line | sel_wrap);
`endif

  // Per-lane source select; guard states force the idle value on every lane at once
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
`ifdef LOOPBACK_MUX_SIPO_PRBS_EN
    assign data_next[gi] = prbs_on  ? prbs_reg[6] :
                           sel_line ? PMD_UNITDATA_indication[gi] :
                           sel_wrap ? serial_sipo[gi] : IDLE_BIT;
`else
    assign data_next[gi] = sel_line ? PMD_UNITDATA_indication[gi] :
                           sel_wrap ? serial_sipo[gi] : IDLE_BIT;
`endif
  end

  // Output registers, driven from the next state so data latency is one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mux_sipo_out   <= {LANES{IDLE_BIT}};
      wrap_active    <= 1'b0;
      switching      <= 1'b0;
      sel_change_cnt <= 8'd0;
    end else begin
      mux_sipo_out <= data_next;
      wrap_active  <= sel_wrap;
      switching    <= (state_next == G2WRAP) || (state_next == G2LINE);
      if (guard_done && (sel_change_cnt != 8'hFF))
        sel_change_cnt <= sel_change_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_loopback_mux_sipo.sv
// Bench for loopback_mux_sipo (LANES=4, SYNC_STAGES=2, GUARD=4). Expected outputs are
// pushed to a queue as each cycle's stimulus is driven and popped after the clock edge.
// Build with LOOPBACK_MUX_SIPO_PRBS_EN defined to also exercise the PRBS source.
module tb_loopback_mux_sipo;

  localparam int S = 2;   // synchronizer depth
  localparam int G = 4;   // guard length

  typedef struct packed {
    logic [3:0] out;
    logic       wrap;
    logic       sw;
    logic [7:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] serial_sipo = '0;
  logic [3:0] pmd = '0;
  logic       ewrap = 1'b0;
`ifdef LOOPBACK_MUX_SIPO_PRBS_EN
  logic       prbs_sel = 1'b0;
`endif
  logic [3:0] mux_sipo_out;
  logic       wrap_active;
  logic       switching;
  logic [7:0] sel_change_cnt;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  loopback_mux_sipo #(.LANES(4), .SYNC_STAGES(S), .GUARD(G), .IDLE_BIT(1'b0)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .serial_sipo             (serial_sipo),
    .PMD_UNITDATA_indication (pmd),
    .EWRAP                   (ewrap),
`ifdef LOOPBACK_MUX_SIPO_PRBS_EN
    .prbs_sel                (prbs_sel),
`endif
    .mux_sipo_out            (mux_sipo_out),
    .wrap_active             (wrap_active),
    .switching               (switching),
    .sel_change_cnt          (sel_change_cnt)
  );

  task automatic rand_data();
    serial_sipo = 4'($urandom);
    pmd         = 4'($urandom);
  endtask

  // Leaves reset released at a falling edge, inputs quiet
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    ewrap = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e, act;
    @(negedge clk);
    reset = 1'b0;
    ewrap = 1'b1;
    serial_sipo = 4'hF;
    pmd = 4'hF;
`ifdef LOOPBACK_MUX_SIPO_PRBS_EN
    prbs_sel = 1'b1;
`endif
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back('{out: 4'h0, wrap: 1'b0, sw: 1'b0, cnt: 8'd0});
      @(posedge clk); #1;
      e = exp_q.pop_front();
      act = {mux_sipo_out, wrap_active, switching, sel_change_cnt};
      n_cmp++;
      if (act !== e) begin
        n_err++;
        $display("FAIL reset k=%0d got out=%h wrap=%b sw=%b cnt=%0d want out=%h wrap=%b sw=%b cnt=%0d",
                 k, act.out, act.wrap, act.sw, act.cnt, e.out, e.wrap, e.sw, e.cnt);
      end
    end
    @(negedge clk);
    ewrap = 1'b0;
`ifdef LOOPBACK_MUX_SIPO_PRBS_EN
    prbs_sel = 1'b0;
`endif
    reset = 1'b1;
  endtask

  // Full switchover to WRAP at k=0 and back to LINE at k=R
  task automatic test_switchover();
    exp_t e, act;
    localparam int R = 10;
    apply_reset();
    for (int k = 0; k < 22; k++) begin
      ewrap = (k < R);
      rand_data();
      e.wrap = 1'b0;
      e.sw   = 1'b0;
      e.cnt  = 8'((k >= S + G) ? 1 : 0) + 8'((k >= R + S + G) ? 1 : 0);
      if ((k >= S && k < S + G) || (k >= R + S && k < R + S + G)) begin
        e.out = 4'h0;
        e.sw  = 1'b1;
      end else if (k >= S + G && k < R + S) begin
        e.out  = serial_sipo;
        e.wrap = 1'b1;
      end else begin
        e.out = pmd;
      end
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      act = {mux_sipo_out, wrap_active, switching, sel_change_cnt};
      n_cmp++;
      if (act !== e) begin
        n_err++;
        $display("FAIL switchover k=%0d got out=%h wrap=%b sw=%b cnt=%0d want out=%h wrap=%b sw=%b cnt=%0d",
                 k, act.out, act.wrap, act.sw, act.cnt, e.out, e.wrap, e.sw, e.cnt);
      end
      $display("switchover k=%0d ewrap=%b out=%h wrap=%b sw=%b cnt=%0d",
               k, ewrap, act.out, act.wrap, act.sw, act.cnt);
      @(negedge clk);
    end
  endtask

  // EWRAP high for two cycles: aborted guard, full reverse guard, six idle cycles
  task automatic test_abort();
    exp_t e, act;
    apply_reset();
    for (int k = 0; k < 14; k++) begin
      ewrap = (k < 2);
      rand_data();
      e.wrap = 1'b0;
      e.sw   = (k >= S && k <= S + G + 1);
      e.out  = e.sw ? 4'h0 : pmd;
      e.cnt  = (k >= S + G + 2) ? 8'd1 : 8'd0;
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      act = {mux_sipo_out, wrap_active, switching, sel_change_cnt};
      n_cmp++;
      if (act !== e) begin
        n_err++;
        $display("FAIL abort k=%0d got out=%h wrap=%b sw=%b cnt=%0d want out=%h wrap=%b sw=%b cnt=%0d",
                 k, act.out, act.wrap, act.sw, act.cnt, e.out, e.wrap, e.sw, e.cnt);
      end
      $display("abort k=%0d ewrap=%b out=%h sw=%b cnt=%0d", k, ewrap, act.out, act.sw, act.cnt);
      @(negedge clk);
    end
  endtask

  // 300 completed switchovers; the count must stop at 255
  task automatic test_saturation();
    exp_t e, act;
    localparam int PH = S + G + 2;
    apply_reset();
    for (int t = 0; t < 300; t++) begin
      for (int k = 0; k < PH; k++) begin
        ewrap = (t % 2 == 0);
        rand_data();
        if (k == PH - 1) begin
          e.wrap = ewrap;
          e.sw   = 1'b0;
          e.out  = ewrap ? serial_sipo : pmd;
          e.cnt  = (t + 1 > 255) ? 8'd255 : 8'(t + 1);
          exp_q.push_back(e);
        end
        @(posedge clk); #1;
        if (k == PH - 1) begin
          e = exp_q.pop_front();
          act = {mux_sipo_out, wrap_active, switching, sel_change_cnt};
          n_cmp++;
          if (act !== e) begin
            n_err++;
            $display("FAIL saturation t=%0d got out=%h wrap=%b sw=%b cnt=%0d want out=%h wrap=%b sw=%b cnt=%0d",
                     t, act.out, act.wrap, act.sw, act.cnt, e.out, e.wrap, e.sw, e.cnt);
          end
          if (t >= 250) $display("saturation t=%0d cnt=%0d", t, act.cnt);
        end
        @(negedge clk);
      end
    end
  endtask

  // Reset asserted inside G2WRAP, then line data must pass straight through
  task automatic test_reset_mid_guard();
    exp_t e, act;
    apply_reset();
    for (int k = 0; k < 13; k++) begin
      if (k == 4) begin
        reset = 1'b0;
        ewrap = 1'b0;
        exp_q.push_back('{out: 4'h0, wrap: 1'b0, sw: 1'b0, cnt: 8'd0});
        #1;
      end else begin
        if (k == 6) reset = 1'b1;
        ewrap = (k < 4);
        rand_data();
        e.wrap = 1'b0;
        e.cnt  = 8'd0;
        e.sw   = (k >= S && k < 4);
        e.out  = (k == 5 || e.sw) ? 4'h0 : pmd;
        exp_q.push_back(e);
        @(posedge clk); #1;
      end
      e = exp_q.pop_front();
      act = {mux_sipo_out, wrap_active, switching, sel_change_cnt};
      n_cmp++;
      if (act !== e) begin
        n_err++;
        $display("FAIL reset_mid_guard k=%0d got out=%h wrap=%b sw=%b cnt=%0d want out=%h wrap=%b sw=%b cnt=%0d",
                 k, act.out, act.wrap, act.sw, act.cnt, e.out, e.wrap, e.sw, e.cnt);
      end
      $display("reset_mid_guard k=%0d rst=%b out=%h sw=%b", k, reset, act.out, act.sw);
      if (k != 4) @(negedge clk);
    end
  endtask

`ifdef LOOPBACK_MUX_SIPO_PRBS_EN
  // PRBS in LINE for two periods, then a switchover to WRAP with PRBS still selected
  task automatic test_prbs();
    exp_t e, act;
    logic [6:0] lfsr;
    logic       pbit;
    apply_reset();
    lfsr = 7'h7F;
    prbs_sel = 1'b1;
    for (int k = 0; k < 254 + 12; k++) begin
      int j;
      j = k - 254;
      ewrap = (j >= 0);
      rand_data();
      pbit = lfsr[6];
      lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      e.sw   = (j >= S && j < S + G);
      e.wrap = (j >= S + G);
      e.cnt  = (j >= S + G) ? 8'd1 : 8'd0;
      e.out  = e.sw ? 4'h0 : {4{pbit}};
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      act = {mux_sipo_out, wrap_active, switching, sel_change_cnt};
      n_cmp++;
      if (act !== e) begin
        n_err++;
        $display("FAIL prbs k=%0d got out=%h wrap=%b sw=%b cnt=%0d want out=%h wrap=%b sw=%b cnt=%0d",
                 k, act.out, act.wrap, act.sw, act.cnt, e.out, e.wrap, e.sw, e.cnt);
      end
      if (k < 8 || j >= 0) $display("prbs k=%0d out=%h wrap=%b sw=%b", k, act.out, act.wrap, act.sw);
      @(negedge clk);
    end
    prbs_sel = 1'b0;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_switchover();
    test_abort();
    test_saturation();
    test_reset_mid_guard();
`ifdef LOOPBACK_MUX_SIPO_PRBS_EN
    test_prbs();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
